ugt_compare_arbiter: RTL and testbench

- Shares one W-bit unsigned subtract-with-carry comparator (invert I1, CIN=1, ugt taken from carry-out) among N requesters.
- Round-robin arbitration.
- The winner's operands are registered, compared in one cycle, and the result is returned with a valid strobe and the requester ID.
- Sits between icestick datapath clients (counters, threshold checkers) and the single shared compare resource, to save LUTs and carry chains.

---
 rtl/ugt_compare_arbiter.sv | 152 +++++++++++++++
 tb/tb_ugt_compare_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ugt_compare_arbiter.sv
// ugt_compare_arbiter: round-robin front end for one shared W-bit unsigned
// comparator. The winner's operands are captured on grant, compared in the
// following cycle, and the result is presented with VALID and the owner's ID.
// Each transaction takes three cycles: grant, compare, respond.

// Per-lane window test: is this lane's request at or above the RR pointer?
module ugt_compare_arbiter_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           req,
  input  logic [IDW-1:0] ptr,
  output logic           in_window
);
  localparam logic [IDW-1:0] LANE_ID = IDW'(LANE);

  // Lanes below the pointer only win once the upper window is empty
  assign in_window = req && (LANE_ID >= ptr);
endmodule

module ugt_compare_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [N-1:0]     REQ,
  input  logic [N*W-1:0]   A,
  input  logic [N*W-1:0]   B,
  output logic [N-1:0]     GNT,
  output logic             VALID,
  output logic [IDW-1:0]   ID,
  output logic             UGT,
  output logic             EQ,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t               state, state_nxt;
  logic [N-1:0][W-1:0]  a_lane, b_lane;
  logic [N-1:0]         win_mask;
  logic [IDW-1:0]       ptr, ptr_nxt;
  logic [IDW-1:0]       win_hi, win_any, winner;
  logic                 hit_hi, hit_any;
  logic [N-1:0]         gnt_nxt;
  logic [W-1:0]         op_a, op_b;
  logic [W:0]           sum;
  logic                 carry;

  // Flattened operand buses viewed as per-lane words
  assign a_lane = A;
  assign b_lane = B;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      ugt_compare_arbiter_lane #(.IDW(IDW), .LANE(g)) u_lane (
        .req       (REQ[g]),
        .ptr       (ptr),
        .in_window (win_mask[g])
      );
    end
  endgenerate

  // Winner: lowest set bit in the window at/above ptr, else lowest set bit
  // overall (the wrap from N-1 back to 0)
  always_comb begin
    win_hi  = '0;
    hit_hi  = 1'b0;
    win_any = '0;
    hit_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (win_mask[i] && !hit_hi) begin
        win_hi = IDW'(i);
        hit_hi = 1'b1;
      end
      if (REQ[i] && !hit_any) begin
        win_any = IDW'(i);
        hit_any = 1'b1;
      end
    end
    winner  = hit_hi ? win_hi : win_any;
    ptr_nxt = (winner == IDW'(N-1)) ? '0 : winner + 1'b1;
    gnt_nxt = '0;
    gnt_nxt[winner] = 1'b1;
  end

  // Subtract-with-carry: opB + ~opA + 1; carry-out set iff opB >= opA
  assign sum   = {1'b0, op_b} + {1'b0, ~op_a} + (W+1)'(1);
  assign carry = sum[W];

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state: IDLE waits for any request, then CALC and RESP run in order
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|REQ) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, compare and response registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      GNT   <= '0;
      VALID <= 1'b0;
      ID    <= '0;
      UGT   <= 1'b0;
      EQ    <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|REQ) begin
            GNT  <= gnt_nxt;
            op_a <= a_lane[winner];
            op_b <= b_lane[winner];
            ID   <= winner;
            ptr  <= ptr_nxt;
          end
        end
        CALC: begin
          GNT   <= '0;
          UGT   <= ~carry;
          EQ    <= (op_a == op_b);
          VALID <= 1'b1;
        end
        RESP: begin
          VALID <= 1'b0;
        end
        default: begin
          GNT   <= '0;
          VALID <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_ugt_compare_arbiter.sv
// Scoreboard bench for ugt_compare_arbiter: expected grants/results are
// queued when requests are driven and retired when GNT/VALID appear.
module tb_ugt_compare_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  typedef struct {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           ugt;
    logic           eq;
  } exp_t;

  logic                CLK;
  logic                RESETN;
  logic [N-1:0]        REQ;
  logic [N-1:0][W-1:0] a_tb, b_tb;
  logic [N-1:0]        GNT;
  logic                VALID;
  logic [IDW-1:0]      ID;
  logic                UGT, EQ, BUSY;

  exp_t sb[$];
  int   exp_ids[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  ugt_compare_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .A(a_tb), .B(b_tb),
    .GNT(GNT), .VALID(VALID), .ID(ID), .UGT(UGT), .EQ(EQ), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue the expected outcome for requester id from the current operands
  task automatic push_exp(input int id);
    exp_t e;
    e.gnt     = '0;
    e.gnt[id] = 1'b1;
    e.id      = IDW'(id);
    e.ugt     = (a_tb[id] > b_tb[id]);
    e.eq      = (a_tb[id] == b_tb[id]);
    sb.push_back(e);
  endtask

  // Hold REQ=mask for n transactions, expecting winners from exp_ids.
  // Entered and left at the start of an IDLE cycle (#1 after the edge).
  task automatic run_held(input logic [N-1:0] mask, input int n);
    REQ = mask;
    for (int k = 0; k < n; k++) begin
      logic [N-1:0] g;
      g = '0;
      g[exp_ids[k]] = 1'b1;
      push_exp(exp_ids[k]);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("gnt_cycle1", GNT, g);
      check("busy_calc", BUSY, 1);
      @(posedge CLK); #1;
      if (k == n-1) REQ = '0;
      @(negedge CLK);
      check("valid_cycle2", VALID, 1);
      @(posedge CLK); #1;
    end
    exp_ids.delete();
  endtask

  // Monitor: every grant must match the queue head, every VALID retires it
  always @(negedge CLK) begin
    if (RESETN) begin
      if (GNT != '0) begin
        if (sb.size() == 0) check("gnt_unexpected", GNT, 0);
        else                check("sb_gnt", GNT, sb[0].gnt);
      end
      if (VALID) begin
        if (sb.size() == 0) check("valid_unexpected", VALID, 0);
        else begin
          mon_e = sb.pop_front();
          check("sb_id", ID, mon_e.id);
          check("sb_ugt", UGT, mon_e.ugt);
          check("sb_eq", EQ, mon_e.eq);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all requests active: nothing may come out
    RESETN = 1'b0;
    REQ    = '1;
    a_tb   = '0;
    b_tb   = '0;
    for (int i = 0; i < N; i++) begin
      a_tb[i] = W'(8'h50 + i);
      b_tb[i] = W'(8'h10);
    end
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    check("rst_gnt", GNT, 0);
    check("rst_valid", VALID, 0);
    check("rst_id", ID, 0);
    check("rst_ugt", UGT, 0);
    check("rst_eq", EQ, 0);
    check("rst_busy", BUSY, 0);
    @(posedge CLK); #1;
    REQ    = '0;
    RESETN = 1'b1;
    @(posedge CLK); #1;
    check("idle_busy", BUSY, 0);

    // First request after reset: requester 0, 0x05 > 0x03
    a_tb[0] = 8'h05; b_tb[0] = 8'h03;
    exp_ids.push_back(0);
    run_held(4'b0001, 1);

    // Equality and extremes on requester 2
    a_tb[2] = 8'h7F; b_tb[2] = 8'h7F;
    exp_ids.push_back(2);
    run_held(4'b0100, 1);
    a_tb[2] = 8'hFF; b_tb[2] = 8'h00;
    exp_ids.push_back(2);
    run_held(4'b0100, 1);
    a_tb[2] = 8'h00; b_tb[2] = 8'hFF;
    exp_ids.push_back(2);
    run_held(4'b0100, 1);

    // Round robin from a fresh pointer with all requests held
    RESETN = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RESETN = 1'b1;
    a_tb[0] = 8'h10; b_tb[0] = 8'h20;
    a_tb[1] = 8'h90; b_tb[1] = 8'h80;
    a_tb[2] = 8'h33; b_tb[2] = 8'h33;
    a_tb[3] = 8'hFE; b_tb[3] = 8'hFF;
    exp_ids.push_back(0); exp_ids.push_back(1); exp_ids.push_back(2);
    exp_ids.push_back(3); exp_ids.push_back(0);
    run_held(4'b1111, 5);

    // Pointer skip: after requester 1, REQ=1001 serves 3 before 0
    a_tb[1] = 8'h01; b_tb[1] = 8'h02;
    exp_ids.push_back(1);
    run_held(4'b0010, 1);
    a_tb[3] = 8'hC0; b_tb[3] = 8'h0C;
    exp_ids.push_back(3); exp_ids.push_back(0);
    run_held(4'b1001, 2);

    // Mid-operation reset: grant requester 2 (pointer moves to 3), reset in CALC
    REQ = 4'b0100;
    a_tb[2] = 8'hAA; b_tb[2] = 8'h55;
    push_exp(2);
    @(posedge CLK); #1;
    #2;
    check("abort_gnt", GNT, 4'b0100);
    RESETN = 1'b0;
    REQ    = '0;
    #1;
    check("abort_gnt_clr", GNT, 0);
    check("abort_valid", VALID, 0);
    check("abort_busy", BUSY, 0);
    check("abort_id", ID, 0);
    sb.delete();
    @(posedge CLK); @(posedge CLK); #1;
    RESETN = 1'b1;
    // With the pointer back at 0, 1010 grants 1; a stale pointer of 3 would pick 3
    a_tb[1] = 8'h40; b_tb[1] = 8'h41;
    exp_ids.push_back(1);
    run_held(4'b1010, 1);

    // Late request: 3 arrives during requester 0's CALC and waits for IDLE
    a_tb[0] = 8'h80; b_tb[0] = 8'h7F;
    a_tb[3] = 8'h00; b_tb[3] = 8'h00;
    REQ = 4'b0001;
    push_exp(0);
    @(posedge CLK); #1;            // cycle 1 (CALC)
    REQ = 4'b1001;
    @(negedge CLK);
    check("late_gnt0", GNT, 4'b0001);
    @(posedge CLK); #1;            // cycle 2 (RESP)
    REQ = 4'b1000;
    push_exp(3);
    a_tb[0] = 8'h00;               // post-grant change must not affect result
    b_tb[0] = 8'hFF;
    @(negedge CLK);
    check("late_valid0", VALID, 1);
    check("late_ugt0", UGT, 1);
    @(posedge CLK); #1;            // cycle 3 (IDLE)
    @(negedge CLK);
    check("late_idle_busy", BUSY, 0);
    check("late_idle_gnt", GNT, 0);
    @(posedge CLK); #1;            // cycle 4
    @(negedge CLK);
    check("late_gnt3", GNT, 4'b1000);
    @(posedge CLK); #1;            // cycle 5
    REQ = '0;
    @(negedge CLK);
    check("late_valid3", VALID, 1);
    check("late_eq3", EQ, 1);
    @(posedge CLK); @(posedge CLK); @(posedge CLK); #1;
    check("sb_drained", sb.size(), 0);
    check("final_busy", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
